// File: rtl/sti_pkg.sv
// Shared types and helpers for the STI serial link: length codes, deserializer
// FSM states and the maximum frame width.
package sti_pkg;

  localparam int unsigned STI_MAX_BITS = 32;

  typedef enum logic [1:0] {L8, L16, L24, L32} sti_len_e;

  typedef enum logic {StIdle, StRecv} deser_state_e;

  // Length code to bit count: 8 * (code + 1).
  function automatic logic [5:0] len_bits(sti_len_e code);
    return {1'b0, code, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_word_fifo.sv
// Synchronous word FIFO with extended-pointer full/empty detection; a push is
// accepted when full if a pop happens in the same cycle.
module sti_word_fifo #(
  parameter int unsigned Width = 38,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             push_ok_o,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AddrW = $clog2(Depth);

  logic [AddrW:0]   wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_pop;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_pop    = pop_i && !empty_o;
  assign push_ok_o = push_i && (!full_o || do_pop);
  // Head is masked while empty so the outputs read zero out of reset.
  assign rdata_o   = empty_o ? '0 : mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok_o) wptr_q <= wptr_q + 1'b1;
      if (do_pop)    rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sti_deser.sv
// STI serial-to-parallel frame receiver feeding a word FIFO.
// Define STI_DESER_LEN_CHECK_EN to enable frame length checking.
module sti_deser
  import sti_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             so_data,
  input  logic             so_valid,
  input  logic [1:0]       exp_len,
  input  logic             word_ready,
  output logic             word_valid,
  output logic [31:0]      word_data,
  output logic [5:0]       word_len,
  output logic             word_err,
  output logic             frame_err,
  output logic             overflow,
  output logic [CNT_W-1:0] frame_cnt
);
`ifdef STI_DESER_LEN_CHECK_EN
  localparam int unsigned EntryW = 39;
`else
  localparam int unsigned EntryW = 38;
`endif

  deser_state_e      state_q, state_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic              ovl_q, ovl_d;
  logic              overflow_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic              push, pop, push_ok, full, empty, err;
  logic [EntryW-1:0] wdata, rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (so_valid)  state_d = StRecv;
      StRecv:  if (!so_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ovl_d     = ovl_q;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (so_valid) begin
          shreg_d   = {31'b0, so_data};
          bit_cnt_d = 6'd1;
          ovl_d     = 1'b0;
        end
      end
      StRecv: begin
        if (so_valid) begin
          // Bits beyond the word width are dropped but remembered as overlength.
          if (bit_cnt_q < 6'(STI_MAX_BITS)) begin
            shreg_d   = {shreg_q[30:0], so_data};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            ovl_d = 1'b1;
          end
        end else begin
          push = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ovl_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ovl_q     <= ovl_d;
    end
  end

`ifdef STI_DESER_LEN_CHECK_EN
  sti_len_e len_q;
  logic     frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= L8;
      frame_err_q <= 1'b0;
    end else begin
      if (state_q == StIdle && so_valid) len_q <= sti_len_e'(exp_len);
      frame_err_q <= push_ok && err;
    end
  end

  assign err       = (bit_cnt_q != len_bits(len_q)) || ovl_q;
  assign wdata     = {shreg_q, bit_cnt_q, err};
  assign word_err  = rdata[0];
  assign frame_err = frame_err_q;
`else
  logic unused_len_check;
  assign unused_len_check = ^{exp_len, ovl_q};
  assign err       = 1'b0;
  assign wdata     = {shreg_q, bit_cnt_q};
  assign word_err  = 1'b0;
  assign frame_err = 1'b0;
`endif

  assign pop = word_valid && word_ready;

  sti_word_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wdata_i   (wdata),
    .pop_i     (pop),
    .push_ok_o (push_ok),
    .rdata_o   (rdata),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (push_ok)         frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign word_valid = !empty;
  assign word_data  = rdata[EntryW-1 -: 32];
  assign word_len   = rdata[EntryW-33 -: 6];
  assign overflow   = overflow_q;
  assign frame_cnt  = frame_cnt_q;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_sti_deser.sv
// Scoreboard bench for sti_deser: stimulus queues expected words, a monitor
// pops and compares each word the DUT hands over.
module tb_sti_deser;

`ifdef STI_DESER_LEN_CHECK_EN
  localparam logic LenChk = 1'b1;
`else
  localparam logic LenChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, so_data, so_valid, word_ready;
  logic [1:0]  exp_len;
  logic        word_valid, word_err, frame_err, overflow;
  logic [31:0] word_data;
  logic [5:0]  word_len;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  len;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  sti_deser #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .so_data    (so_data),
    .so_valid   (so_valid),
    .exp_len    (exp_len),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_len   (word_len),
    .word_err   (word_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [5:0] l, input logic e);
    exp_t x;
    x.data = d;
    x.len  = l;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Bits go out MSB-first from bits[n-1], followed by one low cycle.
  task automatic send(input logic [63:0] bits, input int n, input logic [1:0] el);
    for (int i = n - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      so_valid = 1'b1;
      so_data  = bits[i];
      exp_len  = el;
    end
    @(posedge clk); #1;
    so_valid = 1'b0;
    so_data  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_valid"}, 64'(word_valid), 64'd0);
    check({tag, "_word_data"},  64'(word_data),  64'd0);
    check({tag, "_word_len"},   64'(word_len),   64'd0);
    check({tag, "_word_err"},   64'(word_err),   64'd0);
    check({tag, "_frame_err"},  64'(frame_err),  64'd0);
    check({tag, "_overflow"},   64'(overflow),   64'd0);
    check({tag, "_frame_cnt"},  64'(frame_cnt),  64'd0);
  endtask

  task automatic drain(input string tag);
    int budget = 60;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 64'(word_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word_data", 64'(word_data), 64'(e.data));
        check("word_len",  64'(word_len),  64'(e.len));
        check("word_err",  64'(word_err),  64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    so_data    = 1'b0;
    so_valid   = 1'b0;
    exp_len    = 2'd0;
    word_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 8-bit frame 0xA5 and its push latency.
    word_ready = 1'b1;
    expect_word(32'h0000_00A5, 6'd8, 1'b0);
    send(64'hA5, 8, 2'd0);
    @(negedge clk);
    check("latency_before_push", 64'(word_valid), 64'd0);
    @(negedge clk);
    check("latency_after_push", 64'(word_valid), 64'd1);
    check("cnt_after_first", 64'(frame_cnt), 64'd1);

    expect_word(32'hDEAD_BEEF, 6'd32, 1'b0);
    send(64'hDEAD_BEEF, 32, 2'd3);
    repeat (3) @(negedge clk);
    check("cnt_after_32", 64'(frame_cnt), 64'd2);

    // Five frames into a four-deep FIFO with the consumer stalled.
    word_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) expect_word(32'(k), 6'd16, 1'b0);
      send(64'(k), 16, 2'd1);
    end
    repeat (2) @(negedge clk);
    check("overflow_set", 64'(overflow), 64'd1);
    check("cnt_after_overflow", 64'(frame_cnt), 64'd6);
    check("full_valid", 64'(word_valid), 64'd1);
    word_ready = 1'b1;
    drain("overflow");
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Length mismatch: 16 bits against an 8-bit code.
    expect_word(32'h0000_ABCD, 6'd16, LenChk);
    send(64'hABCD, 16, 2'd0);
    @(negedge clk);
    check("frame_err_before", 64'(frame_err), 64'd0);
    @(negedge clk);
    check("frame_err_pulse", 64'(frame_err), 64'(LenChk));
    @(negedge clk);
    check("frame_err_after", 64'(frame_err), 64'd0);

    // 40-bit burst keeps only the first 32 bits.
    expect_word(32'h1234_5678, 6'd32, LenChk);
    send(64'h12_3456_78FF, 40, 2'd3);
    repeat (3) @(negedge clk);
    check("cnt_after_long", 64'(frame_cnt), 64'd8);
    drain("long");

    // Reset mid-frame with a word still queued.
    word_ready = 1'b0;
    send(64'h55, 8, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      so_valid = 1'b1;
      so_data  = i[0];
    end
    @(posedge clk); #1;
    rst      = 1'b1;
    so_valid = 1'b0;
    so_data  = 1'b0;
    @(negedge clk);
    check_reset_outputs("midframe_rst");
    @(posedge clk); #1;
    rst        = 1'b0;
    word_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("no_word_after_rst", 64'(word_valid), 64'd0);

    expect_word(32'h0000_003C, 6'd8, 1'b0);
    send(64'h3C, 8, 2'd0);
    repeat (3) @(negedge clk);
    check("cnt_after_rst_frame", 64'(frame_cnt), 64'd1);
    drain("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
